// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute-stage ALU.
// Includes MIPS funct/opcode values, alu_type codes and the mul/div FSM states.
package alu_pkg;
    localparam logic [1:0] T_I = 2'b00;
    localparam logic [1:0] T_R = 2'b01;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 shift-add multiplier / restoring divider on magnitudes.
// done is high in the last step cycle; hi/lo then carry the sign-corrected result.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import alu_pkg::*;

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc, q, m, acc_n, q_n;
    logic               div_r, neg_p, neg_r, a_neg, b_neg;
    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = signed_op & a[WIDTH-1];
    assign b_neg = signed_op & b[WIDTH-1];
    assign done  = cnt == CW'(1);

    // acc holds the running high product or the partial remainder; q the low product or quotient
    always_comb begin
        sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        trial = {acc, q[WIDTH-1]} - {1'b0, m};
        acc_n = div_r ? (trial[WIDTH] ? {acc[WIDTH-2:0], q[WIDTH-1]} : trial[WIDTH-1:0]) : sum[WIDTH:1];
        q_n   = div_r ? {q[WIDTH-2:0], ~trial[WIDTH]} : {sum[0], q[WIDTH-1:1]};
        prod  = neg_p ? -{acc_n, q_n} : {acc_n, q_n};
        hi    = div_r ? (neg_r ? -acc_n : acc_n) : prod[2*WIDTH-1:WIDTH];
        lo    = div_r ? (neg_p ? -q_n : q_n) : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            div_r <= 1'b0;
            neg_p <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            cnt   <= CW'(WIDTH);
            acc   <= '0;
            q     <= a_neg ? -a : a;
            m     <= b_neg ? -b : b;
            div_r <= is_div;
            neg_p <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            acc <= acc_n;
            q   <= q_n;
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: handshaked execute-stage ALU with registered single-cycle ops
// and iterative MULT/DIV writing the architectural HI/LO registers.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_type,
    input  logic [5:0]       opcode,
    input  logic [5:0]       fun,
    input  logic [4:0]       shamt,
    input  logic [15:0]      immediate,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             illegal
);
    import alu_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] hi_q, lo_q, md_hi, md_lo;
    logic [WIDTH-1:0] imm_s, imm_z, add_rr, sub_rr, add_ri, res;
    logic             add_ovf, sub_ovf, addi_ovf, ovf, ill, md_go, wr_hi, wr_lo;
    logic             accept, md_done;

    assign in_ready = state == IDLE;
    assign accept   = in_valid & in_ready;

    assign imm_s    = {{(WIDTH-16){immediate[15]}}, immediate};
    assign imm_z    = {{(WIDTH-16){1'b0}}, immediate};
    assign add_rr   = rs1 + rs2;
    assign sub_rr   = rs1 - rs2;
    assign add_ri   = rs1 + imm_s;
    assign add_ovf  = (rs1[WIDTH-1] == rs2[WIDTH-1]) & (add_rr[WIDTH-1] != rs1[WIDTH-1]);
    assign sub_ovf  = (rs1[WIDTH-1] != rs2[WIDTH-1]) & (sub_rr[WIDTH-1] != rs1[WIDTH-1]);
    assign addi_ovf = (rs1[WIDTH-1] == imm_s[WIDTH-1]) & (add_ri[WIDTH-1] != rs1[WIDTH-1]);

    always_comb begin
        res   = '0;
        ovf   = 1'b0;
        ill   = 1'b0;
        md_go = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        if (alu_type == T_R) begin
            case (fun)
                F_ADD:   begin res = add_rr; ovf = add_ovf; end
                F_ADDU:  res = add_rr;
                F_SUB:   begin res = sub_rr; ovf = sub_ovf; end
                F_SUBU:  res = sub_rr;
                F_AND:   res = rs1 & rs2;
                F_OR:    res = rs1 | rs2;
                F_XOR:   res = rs1 ^ rs2;
                F_NOR:   res = ~(rs1 | rs2);
                F_SLT:   res = {{(WIDTH-1){1'b0}}, $signed(rs1) < $signed(rs2)};
                F_SLTU:  res = {{(WIDTH-1){1'b0}}, rs1 < rs2};
                F_SLL:   res = rs2 << shamt;
                F_SRL:   res = rs2 >> shamt;
                F_SRA:   res = $signed(rs2) >>> shamt;
                F_SLLV:  res = rs2 << rs1[SHW-1:0];
                F_SRLV:  res = rs2 >> rs1[SHW-1:0];
                F_SRAV:  res = $signed(rs2) >>> rs1[SHW-1:0];
                F_MFHI:  res = hi_q;
                F_MFLO:  res = lo_q;
                F_MTHI:  wr_hi = 1'b1;
                F_MTLO:  wr_lo = 1'b1;
                F_MULT, F_MULTU: md_go = 1'b1;
                // a zero divisor is reported at once and never starts the iterator
                F_DIV, F_DIVU: begin md_go = |rs2; ill = ~|rs2; end
                default: ill = 1'b1;
            endcase
        end else if (alu_type == T_I) begin
            case (opcode)
                OP_ADDI:  begin res = add_ri; ovf = addi_ovf; end
                OP_ADDIU: res = add_ri;
                OP_SLTI:  res = {{(WIDTH-1){1'b0}}, $signed(rs1) < $signed(imm_s)};
                OP_SLTIU: res = {{(WIDTH-1){1'b0}}, rs1 < imm_s};
                OP_ANDI:  res = rs1 & imm_z;
                OP_ORI:   res = rs1 | imm_z;
                OP_XORI:  res = rs1 ^ imm_z;
                OP_LUI:   res = imm_s << 16;
                default:  ill = 1'b1;
            endcase
        end else begin
            ill = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && accept && md_go)
            state_n = BUSY;
        else if (state == BUSY && md_done)
            state_n = IDLE;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept & md_go),
        .signed_op (~fun[0]),
        .is_div    (fun[1]),
        .a         (rs1),
        .b         (rs2),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state     <= state_n;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            if (accept && !md_go) begin
                out_valid <= 1'b1;
                result    <= res;
                overflow  <= ovf;
                illegal   <= ill;
                if (wr_hi) hi_q <= rs1;
                if (wr_lo) lo_q <= rs1;
            end
            if (md_done) begin
                out_valid <= 1'b1;
                result    <= md_lo;
                hi_q      <= md_hi;
                lo_q      <= md_lo;
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench; expected results are pushed at issue and
// popped when out_valid pulses, with latency checked against the accept cycle.
module tb_alu_muldiv;
    import alu_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
        int          lat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_type = 2'b00;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  fun = 6'd0;
    logic [4:0]  shamt = 5'd0;
    logic [15:0] immediate = 16'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        out_valid;
    logic [31:0] result;
    logic        overflow;
    logic        illegal;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        q_exp[$];
    exp_t        got_e;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_type  (alu_type),
        .opcode    (opcode),
        .fun       (fun),
        .shamt     (shamt),
        .immediate (immediate),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour, written from the ISA definition using wide arithmetic
    function automatic exp_t model(input string tag, input logic [1:0] t, input logic [5:0] op,
                                   input logic [5:0] f, input logic [4:0] sh, input logic [15:0] im,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, si, r, rm;
        logic [63:0] p;
        logic [31:0] ui;
        e.tag = tag; e.res = 32'd0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1; e.cyc = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        si = longint'($signed(im));
        ui = si[31:0];
        if (t == T_R) begin
            case (f)
                F_ADD:   begin r = sa + sb; e.res = r[31:0]; e.ovf = r != longint'($signed(r[31:0])); end
                F_ADDU:  e.res = a + b;
                F_SUB:   begin r = sa - sb; e.res = r[31:0]; e.ovf = r != longint'($signed(r[31:0])); end
                F_SUBU:  e.res = a - b;
                F_AND:   e.res = a & b;
                F_OR:    e.res = a | b;
                F_XOR:   e.res = a ^ b;
                F_NOR:   e.res = ~(a | b);
                F_SLT:   e.res = (sa < sb) ? 32'd1 : 32'd0;
                F_SLTU:  e.res = (a < b) ? 32'd1 : 32'd0;
                F_SLL:   e.res = b << sh;
                F_SRL:   e.res = b >> sh;
                F_SRA:   e.res = $signed(b) >>> sh;
                F_SLLV:  e.res = b << a[4:0];
                F_SRLV:  e.res = b >> a[4:0];
                F_SRAV:  e.res = $signed(b) >>> a[4:0];
                F_MFHI:  e.res = m_hi;
                F_MFLO:  e.res = m_lo;
                F_MTHI:  m_hi = a;
                F_MTLO:  m_lo = a;
                F_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; e.lat = 33; end
                F_MULTU: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; e.lat = 33; end
                F_DIV, F_DIVU: begin
                    if (b == 32'd0) e.ill = 1'b1;
                    else begin
                        if (f == F_DIV) begin r = sa / sb; rm = sa % sb; end
                        else begin r = longint'(a) / longint'(b); rm = longint'(a) % longint'(b); end
                        m_lo = r[31:0]; m_hi = rm[31:0]; e.res = m_lo; e.lat = 33;
                    end
                end
                default: e.ill = 1'b1;
            endcase
        end else if (t == T_I) begin
            case (op)
                OP_ADDI:  begin r = sa + si; e.res = r[31:0]; e.ovf = r != longint'($signed(r[31:0])); end
                OP_ADDIU: e.res = a + ui;
                OP_SLTI:  e.res = (sa < si) ? 32'd1 : 32'd0;
                OP_SLTIU: e.res = (a < ui) ? 32'd1 : 32'd0;
                OP_ANDI:  e.res = a & {16'd0, im};
                OP_ORI:   e.res = a | {16'd0, im};
                OP_XORI:  e.res = a ^ {16'd0, im};
                OP_LUI:   e.res = {im, 16'd0};
                default:  e.ill = 1'b1;
            endcase
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic send(input string tag, input logic [1:0] t, input logic [5:0] op, input logic [5:0] f,
                        input logic [4:0] sh, input logic [15:0] im, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
        alu_type = t; opcode = op; fun = f; shamt = sh; immediate = im; rs1 = a; rs2 = b;
        in_valid = 1'b1;
        e = model(tag, t, op, f, sh, im, a, b);
        e.cyc = cyc;
        q_exp.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic r_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh = 5'd0);
        send(tag, T_R, 6'd0, f, sh, 16'd0, a, b);
    endtask

    task automatic i_op(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [15:0] im);
        send(tag, T_I, op, 6'd0, 5'd0, im, a, 32'd0);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (q_exp.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q_exp.size() != 0) check("drain_timeout", 64'(q_exp.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q_exp.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                got_e = q_exp.pop_front();
                check({got_e.tag, "_res"}, 64'(result), 64'(got_e.res));
                check({got_e.tag, "_ovf"}, 64'(overflow), 64'(got_e.ovf));
                check({got_e.tag, "_ill"}, 64'(illegal), 64'(got_e.ill));
                check({got_e.tag, "_lat"}, 64'(cyc - got_e.cyc), 64'(got_e.lat));
            end
        end
    end

    localparam logic [5:0] R_FUNS [20] = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                                         F_SLT, F_SLTU, F_SLL, F_SRA, F_SRLV, F_SRAV, F_MFHI, F_MFLO,
                                         F_MULT, F_MULTU, F_DIV, F_DIVU};

    initial begin
        logic [5:0]  f;
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        r_op("mfhi_rst", F_MFHI, 32'd0, 32'd0);
        r_op("mflo_rst", F_MFLO, 32'd0, 32'd0);

        r_op("add_ovf", F_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        r_op("addu", F_ADDU, 32'h7FFF_FFFF, 32'h0000_0001);
        r_op("sub_ovf", F_SUB, 32'h8000_0000, 32'h0000_0001);
        r_op("sub_neg", F_SUB, 32'h0000_0003, 32'h0000_0005);
        r_op("subu", F_SUBU, 32'h8000_0000, 32'h0000_0001);
        i_op("addi", OP_ADDI, 32'd5, 16'hFFFF);
        i_op("addi_ovf", OP_ADDI, 32'h8000_0000, 16'hFFFF);
        i_op("addiu", OP_ADDIU, 32'h8000_0000, 16'hFFFF);
        i_op("ori", OP_ORI, 32'd0, 16'h8000);
        i_op("andi", OP_ANDI, 32'hFFFF_FFFF, 16'h8421);
        i_op("xori", OP_XORI, 32'h1234_5678, 16'hFFFF);
        i_op("lui", OP_LUI, 32'd0, 16'h1234);
        i_op("lui_neg", OP_LUI, 32'd0, 16'h8001);
        i_op("slti", OP_SLTI, 32'hFFFF_FFFE, 16'hFFFF);
        i_op("sltiu", OP_SLTIU, 32'h0000_0005, 16'hFFFF);
        r_op("slt", F_SLT, 32'hFFFF_FFFF, 32'd1);
        r_op("sltu", F_SLTU, 32'hFFFF_FFFF, 32'd1);
        r_op("nor", F_NOR, 32'hF0F0_0000, 32'h0000_0F0F);
        r_op("sll", F_SLL, 32'd0, 32'h8000_0001, 5'd3);
        r_op("srl", F_SRL, 32'd0, 32'h8000_0000, 5'd31);
        r_op("sra", F_SRA, 32'd0, 32'h8000_0000, 5'd31);
        r_op("srav", F_SRAV, 32'd4, 32'h8000_0000);
        r_op("sllv", F_SLLV, 32'd36, 32'h0000_0001);
        r_op("bad_funct", F_ADD | 6'b011111, 32'h1, 32'h2);
        send("bad_type", 2'b10, OP_ADDI, F_ADD, 5'd0, 16'd1, 32'h7FFF_FFFF, 32'd1);
        i_op("bad_opcode", 6'b000100, 32'd1, 16'd1);
        drain();

        r_op("mult", F_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_busy", 64'(in_ready), 64'd0);
        r_op("mfhi_mult", F_MFHI, 32'd0, 32'd0);
        r_op("multu", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        r_op("mfhi_multu", F_MFHI, 32'd0, 32'd0);
        r_op("div", F_DIV, 32'hFFFF_FFF9, 32'd2);
        r_op("mfhi_div", F_MFHI, 32'd0, 32'd0);
        r_op("divu_zero", F_DIVU, 32'd7, 32'd0);
        r_op("mfhi_dz", F_MFHI, 32'd0, 32'd0);
        r_op("mflo_dz", F_MFLO, 32'd0, 32'd0);
        r_op("div_minneg", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        r_op("mfhi_minneg", F_MFHI, 32'd0, 32'd0);
        r_op("divu", F_DIVU, 32'hFFFF_FFFF, 32'd7);
        r_op("mfhi_divu", F_MFHI, 32'd0, 32'd0);
        r_op("div_negrem", F_DIV, 32'd7, 32'hFFFF_FFFE);
        r_op("mfhi_negrem", F_MFHI, 32'd0, 32'd0);
        r_op("mthi", F_MTHI, 32'hA5A5_0001, 32'd0);
        r_op("mtlo", F_MTLO, 32'h5A5A_0002, 32'd0);
        r_op("mfhi_mt", F_MFHI, 32'd0, 32'd0);
        r_op("mflo_mt", F_MFLO, 32'd0, 32'd0);
        drain();

        for (int i = 0; i < 40; i++) begin
            f = R_FUNS[$urandom_range(19)];
            a = $urandom;
            b = ($urandom_range(7) == 0) ? 32'd0 : $urandom >> $urandom_range(31);
            r_op("rnd", f, a, b, 5'($urandom_range(31)));
        end
        drain();

        r_op("mult_abort", F_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        q_exp.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        r_op("mfhi_abort", F_MFHI, 32'd0, 32'd0);
        r_op("mflo_abort", F_MFLO, 32'd0, 32'd0);
        r_op("add_after", F_ADD, 32'd100, 32'd23);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
